// File: rtl/ifa_pkg.sv
// ifa_pkg: shared types and default parameters for the ifa_p request/grant bus.
package ifa_pkg;

  // Operation codes carried on bus.mode.
  typedef enum logic [1:0] {
    MODE_READ  = 2'b00,
    MODE_WRITE = 2'b01,
    MODE_CLEAR = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  // Slave transaction state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_BUSY  = 2'b10,
    ST_RESP  = 2'b11
  } slv_state_e;

  localparam int IFA_AW       = 5;
  localparam int IFA_DW       = 32;
  localparam int IFA_DEPTH    = 32;
  localparam int IFA_WAIT_CYC = 1;
  localparam int IFA_GNT_TMO  = 8;

  // True for the operations that modify a storage word.
  function automatic logic mode_writes(input mode_e m);
    logic w;
    case (m)
      MODE_WRITE, MODE_CLEAR: w = 1'b1;
      default:                w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ifa_p.sv
// ifa_p: request/grant bus between one master and one slave, with a shared
// bidirectional data bus (master drives write data, slave drives read data).
interface ifa_p
  import ifa_pkg::*;
#(
  parameter int AW = IFA_AW,
  parameter int DW = IFA_DW
);
  logic          req;
  logic          start;
  logic [AW-1:0] addr;
  mode_e         mode;
  wire  [DW-1:0] data;
  logic          gnt;
  logic          rdy;
  logic          err;

  modport master (
    output req, start, addr, mode,
    inout  data,
    input  gnt, rdy, err
  );

  modport slave (
    input  req, start, addr, mode,
    inout  data,
    output gnt, rdy, err
  );
endinterface

// File: rtl/mem_array.sv
// mem_array: synchronous single-port storage with a registered read port.
// The array itself carries no reset; only the read register is cleared.
module mem_array #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Storage write; callers guarantee addr < DEPTH whenever we is set.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read; holds the last read word between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= {DW{1'b0}};
    end else if (re) begin
      rdata <= mem[addr];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/mem_slave_p.sv
// mem_slave_p: parametrised memory slave on ifa_p. One transaction at a
// time: req -> gnt -> start -> WAIT_CYC busy cycles -> one-cycle rdy.
// Out-of-range addresses and the reserved mode complete with err=1.
module mem_slave_p
  import ifa_pkg::*;
#(
  parameter int AW       = IFA_AW,
  parameter int DW       = IFA_DW,
  parameter int DEPTH    = IFA_DEPTH,
  parameter int WAIT_CYC = IFA_WAIT_CYC,
  parameter int GNT_TMO  = IFA_GNT_TMO
) (
  input logic clk,
  input logic rst_n,
  ifa_p.slave bus
);

  // Counter widths: wait counter holds WAIT_CYC-1, timeout counter GNT_TMO-1.
  localparam int WCW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam int TCW = (GNT_TMO > 1) ? $clog2(GNT_TMO) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_CYC - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'((GNT_TMO > 0) ? (GNT_TMO - 1) : 0);
  localparam logic           TMO_EN    = (GNT_TMO > 0) ? 1'b1 : 1'b0;
  // One extra bit so DEPTH == 2**AW is representable.
  localparam logic [AW:0]    DEPTH_LIM = (AW + 1)'(DEPTH);

  slv_state_e    state;
  slv_state_e    state_nxt;
  logic [WCW-1:0] wait_cnt;
  logic [TCW-1:0] tmo_cnt;

  logic [AW-1:0] addr_q;
  mode_e         mode_q;
  logic [DW-1:0] wdata_q;

  logic          gnt_q;
  logic          rdy_q;
  logic          err_q;
  logic          data_oe;
  logic          rd_ok_q;

  logic          accept_s;
  logic          finish_s;
  logic          in_range_s;
  logic          acc_err_s;
  logic          mem_we_s;
  logic          mem_re_s;
  logic [DW-1:0] mem_wdata_s;
  logic [DW-1:0] mem_rdata_s;
  logic [DW-1:0] rsp_data_s;

  // Next-state selection plus the accept/finish strobes of the handshake.
  always_comb begin
    state_nxt = state;
    accept_s  = 1'b0;
    finish_s  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req) begin
          state_nxt = ST_GRANT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // start wins over a timeout landing in the same cycle.
        if (bus.start) begin
          accept_s  = 1'b1;
          state_nxt = ST_BUSY;
        end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_GRANT;
        end
      end
      ST_BUSY: begin
        if (wait_cnt == {WCW{1'b0}}) begin
          finish_s  = 1'b1;
          state_nxt = ST_RESP;
        end else begin
          state_nxt = ST_BUSY;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Range check and storage strobes for the latched transaction.
  always_comb begin
    in_range_s  = ({1'b0, addr_q} < DEPTH_LIM);
    acc_err_s   = (!in_range_s) || (mode_q == MODE_RSVD);
    mem_we_s    = finish_s && in_range_s && mode_writes(mode_q);
    mem_re_s    = finish_s && in_range_s && (mode_q == MODE_READ);
    if (mode_q == MODE_CLEAR) begin
      mem_wdata_s = {DW{1'b0}};
    end else begin
      mem_wdata_s = wdata_q;
    end
  end

  // State register and registered bus outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      gnt_q   <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      data_oe <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt_q   <= (state_nxt == ST_GRANT);
      rdy_q   <= (state_nxt == ST_RESP);
      err_q   <= (state_nxt == ST_RESP) && acc_err_s;
      data_oe <= (state_nxt == ST_RESP) && (mode_q == MODE_READ);
      // An out-of-range read still drives the bus, but with zeros.
      if (finish_s) begin
        rd_ok_q <= mem_re_s;
      end else begin
        rd_ok_q <= rd_ok_q;
      end
    end
  end

  // Wait counter: loaded on accept, counts down through BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= {WCW{1'b0}};
    end else if (accept_s) begin
      wait_cnt <= WAIT_LOAD;
    end else if ((state == ST_BUSY) && (wait_cnt != {WCW{1'b0}})) begin
      wait_cnt <= wait_cnt - WCW'(1);
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Grant timeout counter: counts idle GRANT cycles, zero everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= {TCW{1'b0}};
    end else if ((state == ST_GRANT) && (state_nxt == ST_GRANT)) begin
      tmo_cnt <= tmo_cnt + TCW'(1);
    end else begin
      tmo_cnt <= {TCW{1'b0}};
    end
  end

  // Transaction latch: addr, mode and write data captured on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= {AW{1'b0}};
      mode_q  <= MODE_READ;
      wdata_q <= {DW{1'b0}};
    end else if (accept_s) begin
      addr_q  <= bus.addr;
      mode_q  <= bus.mode;
      wdata_q <= bus.data;
    end else begin
      addr_q  <= addr_q;
      mode_q  <= mode_q;
      wdata_q <= wdata_q;
    end
  end

  mem_array #(
    .AW   (AW),
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (mem_we_s),
    .re   (mem_re_s),
    .addr (addr_q),
    .wdata(mem_wdata_s),
    .rdata(mem_rdata_s)
  );

  assign rsp_data_s = rd_ok_q ? mem_rdata_s : {DW{1'b0}};
  assign bus.data   = data_oe ? rsp_data_s : {DW{1'bz}};
  assign bus.gnt    = gnt_q;
  assign bus.rdy    = rdy_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_mem_slave_p.sv
// tb_mem_slave_p: directed bench for mem_slave_p. A transaction-level model
// (word array plus the handshake timeline) sets per-cycle expectations that
// one compare process checks on every falling edge.
module tb_mem_slave_p;
  import ifa_pkg::*;

  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int DEPTH    = 24;
  localparam int WAIT_CYC = 2;
  localparam int GNT_TMO  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  ifa_p #(.AW(AW), .DW(DW)) bus_if ();
  ifa_p #(.AW(AW), .DW(DW)) bus1 ();

  logic        mst_oe = 1'b0;
  logic [31:0] mst_data = 32'h0;
  logic        m1_oe = 1'b0;
  logic [31:0] m1_data = 32'h0;
  assign bus_if.data = mst_oe ? mst_data : {32{1'bz}};
  assign bus1.data   = m1_oe ? m1_data : {32{1'bz}};

  mem_slave_p #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .WAIT_CYC(WAIT_CYC), .GNT_TMO(GNT_TMO))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

  mem_slave_p #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .WAIT_CYC(1), .GNT_TMO(GNT_TMO))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Model state and per-cycle expectations.
  logic [31:0] model_mem [DEPTH];
  logic        exp_gnt = 1'b0;
  logic        exp_rdy = 1'b0;
  logic        exp_err = 1'b0;
  logic        exp_oe  = 1'b0;
  logic [31:0] exp_data = 32'h0;

  int          start_cyc = 0;
  int          rdy_cyc = 0;
  int          rdy_count = 0;
  int          gnt_count = 0;
  logic [31:0] last_data = 32'h0;
  logic        last_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: DUT outputs against the model, every cycle.
  always @(negedge clk) begin
    chk("gnt", 32'(bus_if.gnt), 32'(exp_gnt));
    chk("rdy", 32'(bus_if.rdy), 32'(exp_rdy));
    chk("drive_en", 32'(dut.data_oe), 32'(exp_oe));
    if (exp_rdy) chk("err", 32'(bus_if.err), 32'(exp_err));
    if (exp_oe) chk("rdata", bus_if.data, exp_data);
    if (bus_if.gnt) gnt_count++;
    if (bus_if.rdy) begin
      rdy_cyc   = cyc;
      last_data = bus_if.data;
      last_err  = bus_if.err;
      rdy_count++;
    end
  end

  task automatic all_zero(input string nm);
    chk({nm, "_gnt"}, 32'(bus_if.gnt), 32'd0);
    chk({nm, "_rdy"}, 32'(bus_if.rdy), 32'd0);
    chk({nm, "_err"}, 32'(bus_if.err), 32'd0);
    chk({nm, "_oe"},  32'(dut.data_oe), 32'd0);
  endtask

  // One transaction on dut, starting in an IDLE cycle and ending in the
  // next IDLE cycle. rst_at: 0 none, 1 reset in first BUSY cycle, 2 in RESP.
  task automatic do_txn(input int a, input mode_e m, input logic [31:0] wd, input int rst_at);
    logic        e;
    logic [31:0] d;
    bus_if.req = 1'b1;
    tick();
    exp_gnt = 1'b1;
    bus_if.req = 1'b0;
    bus_if.start = 1'b1;
    bus_if.addr = AW'(a);
    bus_if.mode = m;
    mst_oe = 1'b1;
    mst_data = wd;
    start_cyc = cyc;
    tick();
    exp_gnt = 1'b0;
    bus_if.start = 1'b0;
    mst_oe = 1'b0;
    if (rst_at == 1) begin
      rst_n = 1'b0;
      #1;
      all_zero("rst_busy");
      tick();
      rst_n = 1'b1;
      tick();
      return;
    end
    repeat (WAIT_CYC) tick();
    e = (a >= DEPTH) || (m == MODE_RSVD);
    d = 32'h0;
    if (!e) begin
      case (m)
        MODE_WRITE: model_mem[a] = wd;
        MODE_CLEAR: model_mem[a] = 32'h0;
        MODE_READ:  d = model_mem[a];
        default:    d = 32'h0;
      endcase
    end
    exp_rdy  = 1'b1;
    exp_err  = e;
    exp_oe   = (m == MODE_READ);
    exp_data = d;
    if (rst_at == 2) begin
      rst_n = 1'b0;
      exp_rdy = 1'b0;
      exp_err = 1'b0;
      exp_oe  = 1'b0;
      #1;
      all_zero("rst_resp");
      tick();
      rst_n = 1'b1;
      tick();
      return;
    end
    tick();
    exp_rdy = 1'b0;
    exp_err = 1'b0;
    exp_oe  = 1'b0;
  endtask

  // Transaction on dut1 (WAIT_CYC=1), checked inline with bounded waits.
  task automatic d1_txn(input int a, input mode_e m, input logic [31:0] wd,
                        output int lat, output logic e, output logic [31:0] d);
    int n;
    int s;
    lat = -1;
    e = 1'b0;
    d = 32'h0;
    bus1.req = 1'b1;
    tick();
    n = 0;
    while (!bus1.gnt && n < 8) begin
      tick();
      n++;
    end
    chk("d1_gnt", 32'(bus1.gnt), 32'd1);
    bus1.req = 1'b0;
    bus1.start = 1'b1;
    bus1.addr = AW'(a);
    bus1.mode = m;
    m1_oe = 1'b1;
    m1_data = wd;
    s = cyc;
    tick();
    bus1.start = 1'b0;
    m1_oe = 1'b0;
    n = 0;
    while (!bus1.rdy && n < 8) begin
      tick();
      n++;
    end
    chk("d1_rdy", 32'(bus1.rdy), 32'd1);
    lat = cyc - s;
    e = bus1.err;
    d = bus1.data;
    tick();
  endtask

  initial begin
    int          c0;
    int          g0;
    int          lat;
    logic        e1;
    logic [31:0] d1;

    rst_n = 1'b0;
    bus_if.req = 1'b0;
    bus_if.start = 1'b0;
    bus_if.addr = '0;
    bus_if.mode = MODE_READ;
    bus1.req = 1'b0;
    bus1.start = 1'b0;
    bus1.addr = '0;
    bus1.mode = MODE_READ;
    repeat (2) tick();
    all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Write then read back, with latency pinned by a literal.
    do_txn(3, MODE_WRITE, 32'hDEAD_BEEF, 0);
    do_txn(3, MODE_READ, 32'h0, 0);
    chk("rd_beef", last_data, 32'hDEAD_BEEF);
    chk("rd_beef_err", 32'(last_err), 32'd0);
    chk("latency", 32'(rdy_cyc - start_cyc), 32'd3);

    // Clear then read.
    do_txn(3, MODE_CLEAR, 32'hFFFF_FFFF, 0);
    do_txn(3, MODE_READ, 32'h0, 0);
    chk("rd_clr", last_data, 32'h0000_0000);

    // Out-of-range write/read; addr 25 must not alias onto addr 1.
    do_txn(1, MODE_WRITE, 32'hA5A5_0001, 0);
    do_txn(25, MODE_WRITE, 32'h0BAD_0BAD, 0);
    chk("oor_wr_err", 32'(last_err), 32'd1);
    do_txn(25, MODE_READ, 32'h0, 0);
    chk("oor_rd_data", last_data, 32'h0);
    chk("oor_rd_err", 32'(last_err), 32'd1);

    // Reserved mode: error, no storage change.
    do_txn(1, MODE_RSVD, 32'h1111_2222, 0);
    chk("rsvd_err", 32'(last_err), 32'd1);
    do_txn(1, MODE_READ, 32'h0, 0);
    chk("rd_a1", last_data, 32'hA5A5_0001);

    // Range boundary: DEPTH-1 valid, DEPTH invalid.
    do_txn(23, MODE_WRITE, 32'h2323_2323, 0);
    do_txn(23, MODE_READ, 32'h0, 0);
    chk("rd_last", last_data, 32'h2323_2323);
    do_txn(24, MODE_READ, 32'h0, 0);
    chk("rd_depth_err", 32'(last_err), 32'd1);

    // Grant timeout: gnt for exactly GNT_TMO cycles, no rdy.
    c0 = rdy_count;
    g0 = gnt_count;
    bus_if.req = 1'b1;
    tick();
    bus_if.req = 1'b0;
    repeat (GNT_TMO) begin
      exp_gnt = 1'b1;
      tick();
    end
    exp_gnt = 1'b0;
    repeat (3) tick();
    chk("tmo_gnt_cycles", 32'(gnt_count - g0), 32'd4);
    chk("tmo_no_rdy", 32'(rdy_count - c0), 32'd0);
    do_txn(7, MODE_WRITE, 32'h0707_7070, 0);
    do_txn(7, MODE_READ, 32'h0, 0);
    chk("rd_after_tmo", last_data, 32'h0707_7070);

    // Reset during BUSY loses the write; reset during RESP drops rdy at once.
    do_txn(5, MODE_WRITE, 32'h5555_AAAA, 0);
    do_txn(5, MODE_WRITE, 32'h0000_1234, 1);
    do_txn(5, MODE_READ, 32'h0, 0);
    chk("rd_after_rst", last_data, 32'h5555_AAAA);
    do_txn(5, MODE_READ, 32'h0, 2);
    do_txn(7, MODE_READ, 32'h0, 0);
    chk("rd_after_rst2", last_data, 32'h0707_7070);

    // WAIT_CYC=1 instance: rdy two cycles after start.
    d1_txn(5, MODE_WRITE, 32'h0000_1234, lat, e1, d1);
    chk("d1_wr_lat", 32'(lat), 32'd2);
    chk("d1_wr_err", 32'(e1), 32'd0);
    d1_txn(5, MODE_READ, 32'h0, lat, e1, d1);
    chk("d1_rd_lat", 32'(lat), 32'd2);
    chk("d1_rd_data", d1, 32'h0000_1234);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
